// File: rtl/wptr_full.sv
// Write-side pointer and full-flag logic for an asynchronous FIFO.
// Holds the binary write pointer and publishes it Gray-coded to the read
// domain. It compares against the synchronized read pointer to produce
// a registered full flag, an occupancy level and a sticky overflow flag.
module wptr_full #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              winc,
  input  logic [ADDR_W:0]   wq2_rptr,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  output logic              wfull,
  output logic [ADDR_W:0]   wlevel,
  output logic              wovf
);

  localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  // Inverting the two MSBs of a Gray pointer maps "same slot, one lap
  // apart" onto equality, which is exactly the full condition.
  localparam logic [ADDR_W:0] FULL_MASK = {2'b11, {(ADDR_W-1){1'b0}}};

  // Binary to Gray conversion.
  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary conversion: each bit is the XOR of all Gray bits at or above it.
  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_W:0] wbin_r;
  logic [ADDR_W:0] wptr_r;
  logic            wfull_r;
  logic [ADDR_W:0] wlevel_r;
  logic            wovf_r;

  logic            accept_s;
  logic [ADDR_W:0] wbin_next_s;
  logic [ADDR_W:0] wgray_next_s;
  logic [ADDR_W:0] rbin_s;
  logic            wfull_next_s;
  logic [ADDR_W:0] wlevel_next_s;
  logic            wovf_next_s;

  // Next-state computation: the write decision uses only the registered full flag.
  always_comb begin
    accept_s      = 1'b0;
    wbin_next_s   = wbin_r;
    wgray_next_s  = PTR_ZERO;
    rbin_s        = PTR_ZERO;
    wfull_next_s  = 1'b0;
    wlevel_next_s = PTR_ZERO;
    wovf_next_s   = wovf_r;

    accept_s = winc & ~wfull_r;
    if (accept_s) begin
      wbin_next_s = wbin_r + PTR_ONE;
    end else begin
      wbin_next_s = wbin_r;
    end
    wgray_next_s = bin2gray(wbin_next_s);
    rbin_s       = gray2bin(wq2_rptr);
    if (wgray_next_s == (wq2_rptr ^ FULL_MASK)) begin
      wfull_next_s = 1'b1;
    end else begin
      wfull_next_s = 1'b0;
    end
    wlevel_next_s = wbin_next_s - rbin_s;
    if (winc && wfull_r) begin
      wovf_next_s = 1'b1;
    end else begin
      wovf_next_s = wovf_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbin_r   <= PTR_ZERO;
      wptr_r   <= PTR_ZERO;
      wfull_r  <= 1'b0;
      wlevel_r <= PTR_ZERO;
      wovf_r   <= 1'b0;
    end else begin
      wbin_r   <= wbin_next_s;
      wptr_r   <= wgray_next_s;
      wfull_r  <= wfull_next_s;
      wlevel_r <= wlevel_next_s;
      wovf_r   <= wovf_next_s;
    end
  end

  assign waddr  = wbin_r[ADDR_W-1:0];
  assign wptr   = wptr_r;
  assign wfull  = wfull_r;
  assign wlevel = wlevel_r;
  assign wovf   = wovf_r;

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full (ADDR_W=3). A behavioural model tracks
// the write count, the read position and the occupancy as plain integers.
module tb_wptr_full;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       winc = 1'b0;
  logic [3:0] wq2_rptr = 4'd0;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wfull;
  logic [3:0] wlevel;
  logic       wovf;

  int checks = 0;
  int failures = 0;

  // Model state: positions are kept modulo 16 (two laps of an 8-deep FIFO).
  int m_wpos = 0;
  int m_rpos = 0;
  int m_level = 0;
  bit m_full = 1'b0;
  bit m_ovf = 1'b0;

  wptr_full #(.ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .waddr(waddr), .wptr(wptr), .wfull(wfull), .wlevel(wlevel), .wovf(wovf)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] to_gray(input int n);
    int m;
    m = n % 16;
    return 4'(m ^ (m >> 1));
  endfunction

  // One clock: drive inputs, take the edge, update the model, sample 1ns later.
  task automatic step(input logic rst_i, input logic winc_i, input int rpos_i);
    bit accepted;
    rst_n    = rst_i;
    winc     = winc_i;
    wq2_rptr = to_gray(rpos_i);
    @(posedge clk);
    #1;
    if (!rst_i) begin
      m_wpos = 0; m_rpos = 0; m_level = 0; m_full = 1'b0; m_ovf = 1'b0;
    end else begin
      m_rpos   = rpos_i % 16;
      accepted = winc_i && !m_full;
      if (winc_i && m_full) m_ovf = 1'b1;
      if (accepted) m_wpos = (m_wpos + 1) % 16;
      m_level = (m_wpos - m_rpos + 16) % 16;
      m_full  = (m_level == 8);
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 5);
    checks++;
    if (wptr !== 4'b0000 || waddr !== 3'b000 || wfull !== 1'b0 || wlevel !== 4'd0 || wovf !== 1'b0) begin
      failures++;
      $display("FAIL reset: wptr=%b waddr=%b wfull=%b wlevel=%0d wovf=%b, required all zero",
               wptr, waddr, wfull, wlevel, wovf);
    end
  endtask

  task automatic test_fill();
    logic [3:0] seq [8];
    seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 0);
      checks++;
      if (wptr !== seq[i]) begin
        failures++;
        $display("FAIL fill_wptr[%0d]: got %b, required %b", i, wptr, seq[i]);
      end
    end
    checks++;
    if (wfull !== 1'b1 || wlevel !== 4'd8 || waddr !== 3'b000 || wovf !== 1'b0) begin
      failures++;
      $display("FAIL fill_end: wfull=%b wlevel=%0d waddr=%b wovf=%b, required 1 8 000 0",
               wfull, wlevel, waddr, wovf);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b1, 0);
    checks++;
    if (wptr !== 4'b1100 || wlevel !== 4'd8 || wovf !== 1'b1 || wfull !== 1'b1) begin
      failures++;
      $display("FAIL overflow: wptr=%b wlevel=%0d wovf=%b wfull=%b, required 1100 8 1 1",
               wptr, wlevel, wovf, wfull);
    end
    step(1'b1, 1'b0, 0);
    checks++;
    if (wovf !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: wovf=%b, required 1", wovf);
    end
  endtask

  task automatic test_drain_while_full();
    step(1'b1, 1'b1, 1);
    checks++;
    if (wfull !== 1'b0 || wlevel !== 4'd7 || wptr !== 4'b1100) begin
      failures++;
      $display("FAIL drain_reject: wfull=%b wlevel=%0d wptr=%b, required 0 7 1100", wfull, wlevel, wptr);
    end
    step(1'b1, 1'b1, 1);
    checks++;
    if (wfull !== 1'b1 || wlevel !== 4'd8 || wptr !== 4'b1101) begin
      failures++;
      $display("FAIL drain_refill: wfull=%b wlevel=%0d wptr=%b, required 1 8 1101", wfull, wlevel, wptr);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (waddr !== 3'(i % 8)) begin
        failures++;
        $display("FAIL wrap_waddr[%0d]: got %0d, required %0d", i, waddr, i % 8);
      end
      step(1'b1, 1'b1, m_wpos);
      checks++;
      if (wfull !== 1'b0 || wlevel > 4'd1 || wptr !== to_gray(i + 1)) begin
        failures++;
        $display("FAIL wrap_step[%0d]: wfull=%b wlevel=%0d wptr=%b, required 0 <=1 %b",
                 i, wfull, wlevel, wptr, to_gray(i + 1));
      end
    end
    checks++;
    if (wptr !== 4'b0000) begin
      failures++;
      $display("FAIL wrap_end: wptr=%b, required 0000", wptr);
    end
  endtask

  task automatic test_midop_reset();
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 0);
    checks++;
    if (wlevel !== 4'd5 || wptr !== 4'b0111) begin
      failures++;
      $display("FAIL midop_pre: wlevel=%0d wptr=%b, required 5 0111", wlevel, wptr);
    end
    step(1'b0, 1'b1, 3);
    checks++;
    if (wptr !== 4'd0 || waddr !== 3'd0 || wfull !== 1'b0 || wlevel !== 4'd0 || wovf !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset: wptr=%b waddr=%b wfull=%b wlevel=%0d wovf=%b, required all zero",
               wptr, waddr, wfull, wlevel, wovf);
    end
    step(1'b1, 1'b1, 0);
    checks++;
    if (wptr !== 4'b0001) begin
      failures++;
      $display("FAIL midop_first_write: wptr=%b, required 0001", wptr);
    end
  endtask

  task automatic test_random();
    logic [3:0] prev_wptr;
    int rpos;
    int adv;
    logic rst_v;
    logic winc_v;
    step(1'b0, 1'b0, 0);
    rpos = 0;
    for (int i = 0; i < 600; i++) begin
      prev_wptr = wptr;
      rst_v  = ($urandom_range(0, 79) != 0);
      winc_v = ($urandom_range(0, 99) < 65);
      // The read side may consume anything currently written, never more.
      adv  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, m_level) : 0;
      rpos = (m_rpos + adv) % 16;
      step(rst_v, winc_v, rpos);
      checks++;
      if (wptr !== to_gray(m_wpos) || waddr !== 3'(m_wpos % 8) || wfull !== m_full ||
          wlevel !== 4'(m_level) || wovf !== m_ovf) begin
        failures++;
        $display("FAIL random[%0d]: wptr=%b waddr=%0d wfull=%b wlevel=%0d wovf=%b, required %b %0d %b %0d %b",
                 i, wptr, waddr, wfull, wlevel, wovf, to_gray(m_wpos), m_wpos % 8, m_full, m_level, m_ovf);
      end
      checks++;
      if ($countones(prev_wptr ^ wptr) > 1 && rst_v) begin
        failures++;
        $display("FAIL random_gray_step[%0d]: %b -> %b, required at most one bit change", i, prev_wptr, wptr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_while_full();
    test_wrap();
    test_midop_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
